lu_op_sequencer: RTL and testbench

- Drives the control and operand side of the 2-input AND/NAND/OR/NOR logic unit and reads its result back.
- Outputs A, B, sel_group and sel_op toward the LU and samples its Y output.
- On each start, steps through all 16 combinations of {sel_group, sel_op, A, B} and compares every sample against the expected truth table.
- Reports pass/fail, an error count and the index of the first failing vector. Acts as a self-checking built-in test for the combinational LU.

---
 rtl/lu_op_sequencer.sv | 116 +++++++++++
 tb/tb_lu_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_op_sequencer.sv
// Built-in self test sequencer for the 2-input AND/NAND/OR/NOR logic unit.
// Walks all 16 {sel_group, sel_op, a, b} vectors and checks y_in against the truth table.
module lu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       sel_group,
   output logic       sel_op,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] fail_index,
   output logic [3:0] vec_index
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DRIVE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   logic [2:0] state;
   logic [3:0] settle_cnt;
   logic [3:0] first_fail;
   logic       expected;
   logic       mismatch;

   // The driven vector is the index register itself, so it only moves on DRIVE entry.
   assign {sel_group, sel_op, a_out, b_out} = vec_index;

   always_comb begin
      expected = 1'b0;
      unique case ({sel_group, sel_op})
         2'b00: expected = ~(a_out & b_out);
         2'b01: expected = a_out & b_out;
         2'b10: expected = ~(a_out | b_out);
         2'b11: expected = a_out | b_out;
         default: expected = 1'b0;
      endcase
   end

   assign mismatch = (y_in != expected);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         settle_cnt <= 4'd0;
         first_fail <= 4'd0;
         vec_index  <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 5'd0;
         fail_index <= 4'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_DRIVE;
                  vec_index  <= 4'd0;
                  first_fail <= 4'd0;
                  err_count  <= 5'd0;
                  fail_index <= 4'd0;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            S_DRIVE: begin
               settle_cnt <= SETTLE_LOAD;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (settle_cnt == 4'd0) begin
                  state <= S_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            S_SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + 5'd1;
               end
               if (mismatch && err_count == 5'd0) begin
                  first_fail <= vec_index;
               end
               if (vec_index == 4'd15) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == 5'd0) && !mismatch;
                  // first_fail is not yet updated if vector 15 is the first miss
                  if (err_count == 5'd0 && mismatch) begin
                     fail_index <= vec_index;
                  end else begin
                     fail_index <= first_fail;
                  end
               end else begin
                  vec_index <= vec_index + 4'd1;
                  state     <= S_DRIVE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lu_op_sequencer.sv
// Randomized scoreboard bench for lu_op_sequencer.
// LU fault models feed y_in; a reference model predicts each run's verdict.
module tb_lu_op_sequencer;

   typedef struct {
      int err;
      int fail;
      int pass;
      int lat;
      bit exact;
   } exp_t;

   // Expected LU output indexed by {g, op, a, b}
   localparam logic [15:0] TT = 16'hE187;

   logic clk = 1'b0;
   logic reset;
   logic start1, start3;
   logic y1, y3;
   logic a1, b1, g1, op1, busy1, done1, pass1;
   logic [4:0] err1;
   logic [3:0] fail1, vec1;
   logic a3, b3, g3, op3, busy3, done3, pass3;
   logic [4:0] err3;
   logic [3:0] fail3, vec3;

   int mode;
   logic [15:0] mask;
   logic [2:0] dly1, dly3;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   exp_t q1[$];
   exp_t q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .y_in(y1),
      .a_out(a1), .b_out(b1), .sel_group(g1), .sel_op(op1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_index(fail1), .vec_index(vec1)
   );

   lu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .y_in(y3),
      .a_out(a3), .b_out(b3), .sel_group(g3), .sel_op(op3),
      .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .fail_index(fail3), .vec_index(vec3)
   );

   function automatic logic lu_ideal(logic g, logic op, logic a, logic b);
      logic r;
      r = g ? (a | b) : (a & b);
      return op ? r : ~r;
   endfunction

   // Slow LU: three register stages between its inputs and y
   always @(posedge clk) begin
      dly1 <= {dly1[1:0], lu_ideal(g1, op1, a1, b1)};
      dly3 <= {dly3[1:0], lu_ideal(g3, op3, a3, b3)};
   end

   always_comb begin
      y1 = 1'b0;
      case (mode)
         1: y1 = 1'b0;
         3: y1 = dly1[2];
         default: y1 = lu_ideal(g1, op1, a1, b1) ^ mask[{g1, op1, a1, b1}];
      endcase
   end

   assign y3 = dly3[2];

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   function automatic exp_t ref_run(int m, logic [15:0] msk, int lat);
      exp_t e;
      logic y;
      e.err = 0;
      e.fail = 0;
      e.exact = 1'b1;
      e.lat = lat;
      for (int i = 0; i < 16; i++) begin
         y = (m == 1) ? 1'b0 : (TT[i] ^ msk[i]);
         if (y != TT[i]) begin
            if (e.err == 0) e.fail = i;
            e.err++;
         end
      end
      e.pass = (e.err == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic check_run(string tag, exp_t e, int err, int fail,
                            int pass, int busy, int vec, int lat);
      chk({tag, "_lat"}, lat, e.lat);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_vec"}, vec, 15);
      if (e.exact) begin
         chk({tag, "_err"}, err, e.err);
         chk({tag, "_fail"}, fail, e.fail);
         chk({tag, "_pass"}, pass, e.pass);
      end else begin
         chk({tag, "_err_nz"}, (err > 0) ? 1 : 0, 1);
         chk({tag, "_pass"}, pass, 0);
      end
   endtask

   int t0_1, t0_3;
   logic busy1_q = 1'b0, done1_q = 1'b0;
   logic busy3_q = 1'b0, done3_q = 1'b0;

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (busy1 && !busy1_q) begin
            t0_1 = cyc;
            chk("d1_start_err", int'(err1), 0);
            chk("d1_start_done", int'(done1), 0);
         end
         if (done1 && !done1_q) begin
            if (q1.size() == 0) begin
               chk("d1_unexpected_done", 1, int'(q1.size()));
            end else begin
               check_run("d1", q1.pop_front(), int'(err1), int'(fail1),
                         int'(pass1), int'(busy1), int'(vec1), cyc - t0_1);
            end
         end
      end
      busy1_q = busy1;
      done1_q = done1;
   end

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (busy3 && !busy3_q) t0_3 = cyc;
         if (done3 && !done3_q) begin
            if (q3.size() == 0) begin
               chk("d3_unexpected_done", 1, int'(q3.size()));
            end else begin
               check_run("d3", q3.pop_front(), int'(err3), int'(fail3),
                         int'(pass3), int'(busy3), int'(vec3), cyc - t0_3);
            end
         end
      end
      busy3_q = busy3;
      done3_q = done3;
   end

   task automatic pulse1();
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
   endtask

   task automatic drain1(int limit);
      int n = 0;
      while (q1.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (q1.size() != 0) begin
         chk("d1_timeout", int'(q1.size()), 0);
         q1.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run1(int m, logic [15:0] msk);
      mode = m;
      mask = msk;
      q1.push_back(ref_run(m, msk, 48));
      pulse1();
      drain1(200);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_a"}, int'(a1), 0);
      chk({tag, "_b"}, int'(b1), 0);
      chk({tag, "_g"}, int'(g1), 0);
      chk({tag, "_op"}, int'(op1), 0);
      chk({tag, "_busy"}, int'(busy1), 0);
      chk({tag, "_done"}, int'(done1), 0);
      chk({tag, "_pass"}, int'(pass1), 0);
      chk({tag, "_err"}, int'(err1), 0);
      chk({tag, "_fail"}, int'(fail1), 0);
      chk({tag, "_vec"}, int'(vec1), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=%0d want=0", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int n;
      reset = 1'b1;
      start1 = 1'b0;
      start3 = 1'b0;
      mode = 0;
      mask = 16'h0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      reset = 1'b0;
      @(negedge clk);

      run1(0, 16'h0000);
      run1(1, 16'h0000);
      run1(0, 16'h2000);
      run1(0, 16'h8000);
      for (int k = 0; k < 4; k++) begin
         run1(0, 16'($urandom) & 16'($urandom) & 16'($urandom));
         run1(0, 16'($urandom));
      end

      // Second start mid-run must be ignored
      mode = 0;
      mask = 16'h0;
      q1.push_back(ref_run(0, 16'h0, 48));
      pulse1();
      repeat (8) @(negedge clk);
      pulse1();
      drain1(200);
      repeat (60) @(negedge clk);

      // Start held high: back-to-back runs
      mask = 16'h8421;
      q1.push_back(ref_run(0, mask, 48));
      q1.push_back(ref_run(0, mask, 48));
      @(negedge clk) start1 = 1'b1;
      n = 0;
      while (q1.size() == 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk) start1 = 1'b0;
      drain1(200);

      // Reset in the middle of a failing run
      mode = 1;
      pulse1();
      repeat (19) @(negedge clk);
      chk("mid_busy_before", int'(busy1), 1);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      reset = 1'b0;
      run1(0, 16'h0000);

      // Reset and start together
      @(negedge clk);
      reset = 1'b1;
      start1 = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start1 = 1'b0;
      chk("rst_start_busy", int'(busy1), 0);
      @(negedge clk);
      chk("rst_start_busy2", int'(busy1), 0);

      // Slow LU with too little settle time
      mode = 3;
      e = ref_run(0, 16'h0, 48);
      e.exact = 1'b0;
      q1.push_back(e);
      pulse1();
      drain1(200);

      // Slow LU with enough settle time
      q3.push_back(ref_run(0, 16'h0, 80));
      @(negedge clk) start3 = 1'b1;
      @(negedge clk) start3 = 1'b0;
      n = 0;
      while (q3.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q3.size() != 0) begin
         chk("d3_timeout", int'(q3.size()), 0);
      end
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
